// File: rtl/seg_pkg.sv
// Shared definitions for the segment scan driver and its helpers.
package seg_pkg;

    // Width of one hex digit on the decoder input
    localparam int NIBBLE_W = 4;

    // Widest digit index the driver supports (up to 16 digits)
    localparam int MAX_IDX_W = 4;

    // Bits needed to count n items; never less than one bit
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Index of the digit currently being scanned
    typedef logic [MAX_IDX_W-1:0] digit_idx_t;

    // One hex digit
    typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/seg_prescaler.sv
// Free-running tick generator: one single-cycle tick every DIV clocks.
module seg_prescaler
    import seg_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = idx_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign tick = (count_q == LAST);

    // Count 0..DIV-1 and wrap
    always_comb begin
        count_d = tick ? '0 : count_q + 1'b1;
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Scans an N-digit hex value onto one shared 7-segment decoder. New values
// are buffered and only swapped in at a frame boundary so a frame never
// shows a mix of old and new digits. NUM_DIGITS may be at most 16.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LEAD_BLANK  = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] wr_data,
    output logic [NIBBLE_W-1:0]            data,
    output logic [NUM_DIGITS-1:0]          dig_en,
    output logic                           frame_done
);

    localparam int VW = NIBBLE_W * NUM_DIGITS;
    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    logic                  tick;
    logic                  wrap;
    digit_idx_t            idx_q,        idx_d;
    logic [VW-1:0]         disp_q,       disp_d;
    logic [VW-1:0]         pend_q,       pend_d;
    logic                  pend_full_q,  pend_full_d;
    nibble_t               data_q,       data_d;
    logic [NUM_DIGITS-1:0] dig_en_q,     dig_en_d;
    logic                  frame_done_q, frame_done_d;
    logic [NUM_DIGITS-1:0] digit_visible;
    nibble_t               sel_nib;
    logic                  sel_vis;

    seg_prescaler #(
        .DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap       = tick && (idx_q == LAST_IDX);
    assign wr_ready   = !pend_full_q;
    assign data       = data_q;
    assign dig_en     = dig_en_q;
    assign frame_done = frame_done_q;

    // A digit is shown unless it and every more-significant digit are zero.
    // Digit 0 is always shown so a zero value still displays "0".
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_visible
        if (gi == 0 || LEAD_BLANK == 0) begin : g_always
            assign digit_visible[gi] = 1'b1;
        end else begin : g_blank
            assign digit_visible[gi] = |disp_d[VW-1:gi*NIBBLE_W];
        end
    end

    // Scan index, write buffer and frame-boundary apply
    always_comb begin
        idx_d        = idx_q;
        disp_d       = disp_q;
        pend_d       = pend_q;
        pend_full_d  = pend_full_q;
        frame_done_d = wrap;
        // Apply and accept are exclusive: accept needs an empty buffer,
        // apply needs a full one.
        if (wrap && pend_full_q) begin
            disp_d      = pend_q;
            pend_full_d = 1'b0;
        end
        if (wr_valid && !pend_full_q) begin
            pend_d      = wr_data;
            pend_full_d = 1'b1;
        end
        if (tick) begin
            idx_d = wrap ? '0 : digit_idx_t'(idx_q + 1'b1);
        end
    end

    // Select the nibble and visibility for the digit entered on this tick
    always_comb begin
        sel_nib = '0;
        sel_vis = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (idx_d == digit_idx_t'(j)) begin
                sel_nib = disp_d[j*NIBBLE_W +: NIBBLE_W];
                sel_vis = digit_visible[j];
            end
        end
    end

    // Output next-state: outputs only move on a slot tick
    always_comb begin
        data_d   = data_q;
        dig_en_d = dig_en_q;
        if (tick) begin
            if (sel_vis) begin
                data_d   = sel_nib;
                dig_en_d = NUM_DIGITS'(1) << idx_d;
            end else begin
                data_d   = '0;
                dig_en_d = '0;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_full_q  <= 1'b0;
            data_q       <= '0;
            dig_en_q     <= NUM_DIGITS'(1);
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_full_q  <= pend_full_d;
            data_q       <= data_d;
            dig_en_q     <= dig_en_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: two instances (leading blanking
// on and off) share one stimulus stream and are compared every cycle to a
// frame/slot arithmetic model, plus table-driven per-frame checks.
module tb_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 4;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic [15:0]   wr_data = '0;
    logic          rdy_lb, rdy_nb;
    logic [3:0]    data_lb, data_nb;
    logic [3:0]    en_lb, en_nb;
    logic          fd_lb, fd_nb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .LEAD_BLANK(1)) dut_lb (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy_lb),
        .wr_data(wr_data), .data(data_lb), .dig_en(en_lb), .frame_done(fd_lb)
    );

    seg_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .LEAD_BLANK(0)) dut_nb (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(rdy_nb),
        .wr_data(wr_data), .data(data_nb), .dig_en(en_nb), .frame_done(fd_nb)
    );

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Cycle count since reset gives the slot; the display value changes
    // only when the count crosses a multiple of the frame length.
    bit          m_init = 0;
    int          m_cyc = 0;
    logic [15:0] m_disp = '0;
    logic [15:0] m_pend = '0;
    bit          m_pv = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1;
            m_cyc  <= 0;
            m_disp <= '0;
            m_pv   <= 0;
        end else if (m_init) begin
            m_cyc <= m_cyc + 1;
            if (((m_cyc + 1) % FRAME) == 0 && m_pv) begin
                m_disp <= m_pend;
                m_pv   <= 0;
            end
            if (wr_valid && !m_pv) begin
                m_pend <= wr_data;
                m_pv   <= 1;
            end
        end
    end

    function automatic logic [3:0] exp_en(input int slot, input logic [15:0] v, input int lb);
        logic [15:0] upper;
        upper = v >> (4 * slot);
        if (slot == 0 || lb == 0 || upper != 0) return 4'(1 << slot);
        return 4'h0;
    endfunction

    function automatic logic [3:0] exp_data(input int slot, input logic [15:0] v, input int lb);
        logic [15:0] upper;
        upper = v >> (4 * slot);
        if (exp_en(slot, v, lb) == 4'h0) return 4'h0;
        return upper[3:0];
    endfunction

    int  c_slot;
    bit  c_fd;

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (m_init) begin
            c_slot = (m_cyc / DIV) % N;
            c_fd   = (m_cyc > 0) && ((m_cyc % FRAME) == 0);
            check("model_en_lb",   int'(en_lb),   int'(exp_en(c_slot, m_disp, 1)));
            check("model_data_lb", int'(data_lb), int'(exp_data(c_slot, m_disp, 1)));
            check("model_en_nb",   int'(en_nb),   int'(exp_en(c_slot, m_disp, 0)));
            check("model_data_nb", int'(data_nb), int'(exp_data(c_slot, m_disp, 0)));
            check("model_fd_lb",   int'(fd_lb),   int'(c_fd));
            check("model_fd_nb",   int'(fd_nb),   int'(c_fd));
            check("model_rdy_lb",  int'(rdy_lb),  int'(!m_pv));
            check("model_rdy_nb",  int'(rdy_nb),  int'(!m_pv));
        end
    end

    // ---------------- table of display values ----------------
    // Nibble s of each expected field is the value for slot s.
    typedef struct {
        logic [15:0] value;
        logic [15:0] en1;
        logic [15:0] d1;
        logic [15:0] en0;
        logic [15:0] d0;
    } vec_t;

    vec_t tbl[6];

    // Offer a value and hold wr_valid until it is accepted (bounded)
    task automatic write_value(input logic [15:0] v);
        bit acc;
        acc = 0;
        wr_valid = 1'b1;
        wr_data  = v;
        for (int n = 0; n < 100; n++) begin
            acc = rdy_lb;
            @(negedge clk);
            if (acc) break;
        end
        wr_valid = 1'b0;
        wr_data  = $urandom;
        if (!acc) check("write_timeout", 0, 1);
    endtask

    // Wait for wr_ready to come back: that cycle is the first of the new frame
    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            if (rdy_lb) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_frame_start();
        bit seen;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (fd_lb) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("frame_timeout", 0, 1);
    endtask

    int  pulses;
    bit  ok;
    logic [15:0] t;

    initial begin
        tbl[0] = '{16'h1234, 16'h8421, 16'h1234, 16'h8421, 16'h1234};
        tbl[1] = '{16'h0042, 16'h0021, 16'h0042, 16'h8421, 16'h0042};
        tbl[2] = '{16'h0000, 16'h0001, 16'h0000, 16'h8421, 16'h0000};
        tbl[3] = '{16'h1000, 16'h8421, 16'h1000, 16'h8421, 16'h1000};
        tbl[4] = '{16'hABCD, 16'h8421, 16'hABCD, 16'h8421, 16'hABCD};
        tbl[5] = '{16'h00F0, 16'h0021, 16'h00F0, 16'h8421, 16'h00F0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready",  int'(rdy_lb), 1);
        check("rst_dig_en", int'(en_lb),  1);
        check("rst_data",   int'(data_lb), 0);
        check("rst_fd",     int'(fd_lb),  0);
        rst = 1'b0;

        // Idle: exactly two frame_done pulses in 32 cycles
        pulses = 0;
        for (int n = 0; n < 2 * FRAME; n++) begin
            @(negedge clk);
            if (fd_lb) pulses++;
        end
        check("idle_pulses", pulses, 2);

        // Table-driven: each value appears intact in the frame it is applied
        for (int k = 0; k < 6; k++) begin
            write_value(tbl[k].value);
            check("stall_after_write", int'(rdy_lb), 0);
            wait_ready(ok);
            check("apply_fd", int'(fd_lb), 1);
            for (int s = 0; s < N; s++) begin
                t = tbl[k].en1 >> (4 * s); check("tbl_en_lb",   int'(en_lb),   int'(t[3:0]));
                t = tbl[k].d1  >> (4 * s); check("tbl_data_lb", int'(data_lb), int'(t[3:0]));
                t = tbl[k].en0 >> (4 * s); check("tbl_en_nb",   int'(en_nb),   int'(t[3:0]));
                t = tbl[k].d0  >> (4 * s); check("tbl_data_nb", int'(data_nb), int'(t[3:0]));
                repeat (DIV) @(negedge clk);
            end
        end

        // Back-to-back writes: the second stalls until the first is applied
        write_value(16'hABCD);
        wr_valid = 1'b1;
        wr_data  = 16'h5555;
        wait_ready(ok);
        check("b2b_wrap_fd", int'(fd_lb),   1);
        check("b2b_first",   int'(data_lb), 4'hD);
        @(negedge clk);
        wr_valid = 1'b0;
        check("b2b_accepted", int'(rdy_lb), 0);
        wait_ready(ok);
        check("b2b_second", int'(data_lb), 4'h5);

        // Reset in slot 2 with a write pending
        wait_frame_start();
        repeat (2 * DIV - 1) @(negedge clk);
        write_value(16'hBEEF);
        check("pend_before_rst", int'(rdy_lb), 0);
        check("slot2_en",        int'(en_lb),  4'b0100);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_en",   int'(en_lb),   1);
        check("midrst_data", int'(data_lb), 0);
        check("midrst_rdy",  int'(rdy_lb),  1);
        repeat (2 * FRAME + 1) @(negedge clk);
        check("discarded_rdy",  int'(rdy_lb),  1);
        check("discarded_data", int'(data_lb), 0);

        // Randomized traffic with occasional resets, checked by the model
        for (int n = 0; n < 800; n++) begin
            wr_valid = ($urandom_range(0, 5) == 0);
            wr_data  = 16'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        wr_valid = 1'b0;
        repeat (3 * FRAME) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
